// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcode, width and FSM state definitions shared by alu_ctrl and its bench
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package alu_ctrl_pkg;
    localparam int WORD_SIZE  = `WORD_SIZE;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_INC = 4'd3,
        OP_DEC = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_CMP = 4'd10
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } ctrl_state_t;

    // Encodings above OP_CMP are reserved and retire with cmd_err.
    function automatic logic is_supported(opcode_t op);
        return op <= OP_CMP;
    endfunction

    function automatic logic is_writeback(opcode_t op);
        return is_supported(op) && (op != OP_CMP);
    endfunction
endpackage

// File: rtl/alu_ctrl_alu.sv
// rtl/alu_ctrl_alu.sv - combinational ALU; ext[W] is carry for adds, borrow for subtracts, 0 otherwise
module alu #(
    parameter int W = alu_ctrl_pkg::WORD_SIZE
) (
    input  alu_ctrl_pkg::opcode_t op,
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    output logic [W:0]            ext
);
    import alu_ctrl_pkg::*;

    always_comb begin
        ext = '0;
        case (op)
            OP_ADD, OP_ADC: ext = {1'b0, a} + {1'b0, b};
            OP_SUB, OP_CMP: ext = {1'b0, a} - {1'b0, b};
            OP_INC:         ext = {1'b0, a} + {{W{1'b0}}, 1'b1};
            OP_DEC:         ext = {1'b0, a} - {{W{1'b0}}, 1'b1};
            OP_AND:         ext = {1'b0, a & b};
            OP_OR:          ext = {1'b0, a | b};
            OP_XOR:         ext = {1'b0, a ^ b};
            OP_SHL:         ext = (int'(b) >= W) ? '0 : {1'b0, a << b};
            OP_SHR:         ext = (int'(b) >= W) ? '0 : {1'b0, a >> b};
            default:        ext = '0;
        endcase
    end
endmodule

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - 4-cycle read/exec/writeback sequencer holding Z/C/N flags; ALU_OVF_EN adds flag_v
module alu_ctrl #(
    parameter int WORD_SIZE  = alu_ctrl_pkg::WORD_SIZE,
    parameter int REG_ADDR_W = alu_ctrl_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  alu_ctrl_pkg::opcode_t cmd_opcode,
    input  logic [REG_ADDR_W-1:0] cmd_rd,
    input  logic [REG_ADDR_W-1:0] cmd_rs,
    output logic [REG_ADDR_W-1:0] rf_raddr_a,
    output logic [REG_ADDR_W-1:0] rf_raddr_b,
    input  logic [WORD_SIZE-1:0]  rf_rdata_a,
    input  logic [WORD_SIZE-1:0]  rf_rdata_b,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WORD_SIZE-1:0]  rf_wdata,
    output logic                  done,
    output logic                  cmd_err,
    output logic                  flag_z,
    output logic                  flag_c,
`ifdef ALU_OVF_EN
    output logic                  flag_v,
`endif
    output logic                  flag_n
);
    import alu_ctrl_pkg::*;

    ctrl_state_t          state;
    opcode_t              op_q;
    logic [WORD_SIZE:0]   alu_ext;
    logic [WORD_SIZE:0]   sum;

    alu #(.W(WORD_SIZE)) u_alu (
        .op  (op_q),
        .a   (rf_rdata_a),
        .b   (rf_rdata_b),
        .ext (alu_ext)
    );

    // ADC reuses the ALU's plain add; the carry-in is folded in here.
    assign sum = alu_ext + {{WORD_SIZE{1'b0}}, (op_q == OP_ADC) & flag_c};

`ifdef ALU_OVF_EN
    logic a_msb, b_msb, r_msb, ovf;
    always_comb begin
        a_msb = rf_rdata_a[WORD_SIZE-1];
        b_msb = rf_rdata_b[WORD_SIZE-1];
        r_msb = sum[WORD_SIZE-1];
        ovf   = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC: ovf = (a_msb == b_msb) && (r_msb != a_msb);
            OP_SUB, OP_CMP: ovf = (a_msb != b_msb) && (r_msb != a_msb);
            OP_INC:         ovf = !a_msb && r_msb;
            OP_DEC:         ovf = a_msb && !r_msb;
            default:        ovf = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= OP_ADD;
            cmd_ready  <= 1'b1;
            rf_raddr_a <= '0;
            rf_raddr_b <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            done       <= 1'b0;
            cmd_err    <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_n     <= 1'b0;
`ifdef ALU_OVF_EN
            flag_v     <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            rf_we   <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q       <= cmd_opcode;
                        rf_raddr_a <= cmd_rd;
                        rf_raddr_b <= cmd_rs;
                        rf_waddr   <= cmd_rd;
                        cmd_ready  <= 1'b0;
                        state      <= ST_READ;
                    end
                end
                ST_READ: state <= ST_EXEC;
                ST_EXEC: begin
                    state <= ST_WB;
                    done  <= 1'b1;
                    if (is_supported(op_q)) begin
                        rf_wdata <= sum[WORD_SIZE-1:0];
                        rf_we    <= is_writeback(op_q);
                        flag_z   <= (sum[WORD_SIZE-1:0] == '0);
                        flag_c   <= sum[WORD_SIZE];
                        flag_n   <= sum[WORD_SIZE-1];
`ifdef ALU_OVF_EN
                        flag_v   <= ovf;
`endif
                    end else begin
                        cmd_err <= 1'b1;
                    end
                end
                ST_WB: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - self-checking bench for alu_ctrl with a behavioural arithmetic/flag model
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    localparam int W    = WORD_SIZE;
    localparam int AW   = REG_ADDR_W;
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    opcode_t       cmd_opcode = OP_ADD;
    logic [AW-1:0] cmd_rd = '0;
    logic [AW-1:0] cmd_rs = '0;
    logic [AW-1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [W-1:0]  rf_rdata_a = '0;
    logic [W-1:0]  rf_rdata_b = '0;
    logic [W-1:0]  rf_wdata;
    logic          rf_we, done, cmd_err, flag_z, flag_c, flag_n;
`ifdef ALU_OVF_EN
    logic          flag_v;
`endif

    logic [W-1:0]  rf [1<<AW];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [W-1:0]  ld_data = '0;

    int  total = 0;
    int  bad = 0;
    bit  m_z, m_c, m_n, m_v;

    always #5 clk = ~clk;

    alu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_rd     (cmd_rd),
        .cmd_rs     (cmd_rs),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .done       (done),
        .cmd_err    (cmd_err),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
`ifdef ALU_OVF_EN
        .flag_v     (flag_v),
`endif
        .flag_n     (flag_n)
    );

    // Register file with one-cycle read latency.
    always @(posedge clk) begin
        rf_rdata_a <= rf[rf_raddr_a];
        rf_rdata_b <= rf[rf_raddr_b];
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        if (ld_en) rf[ld_addr] <= ld_data;
    end

    function automatic int sx(input int x);
        return (x >= (1 << (W-1))) ? x - (1 << W) : x;
    endfunction

    function automatic bit ovf_of(input int s);
        return (s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1);
    endfunction

    task automatic model_exec(input int op, input int a, input int b,
                              output int res, output bit we, output bit err);
        int cin;
        cin = int'(m_c);
        res = 0; we = 1'b1; err = 1'b0;
        case (op)
            0:  begin res = (a + b) & MASK;       m_c = (a + b) > MASK;       m_v = ovf_of(sx(a) + sx(b)); end
            1:  begin res = (a + b + cin) & MASK; m_c = (a + b + cin) > MASK; m_v = ovf_of(sx(a) + sx(b) + cin); end
            2:  begin res = (a - b) & MASK;       m_c = a < b;                m_v = ovf_of(sx(a) - sx(b)); end
            3:  begin res = (a + 1) & MASK;       m_c = (a == MASK);          m_v = ovf_of(sx(a) + 1); end
            4:  begin res = (a - 1) & MASK;       m_c = (a == 0);             m_v = ovf_of(sx(a) - 1); end
            5:  begin res = a & b; m_c = 0; m_v = 0; end
            6:  begin res = a | b; m_c = 0; m_v = 0; end
            7:  begin res = a ^ b; m_c = 0; m_v = 0; end
            8:  begin res = (b >= W) ? 0 : (a << b) & MASK; m_c = 0; m_v = 0; end
            9:  begin res = (b >= W) ? 0 : (a >> b);        m_c = 0; m_v = 0; end
            10: begin res = (a - b) & MASK; m_c = a < b; m_v = ovf_of(sx(a) - sx(b)); we = 1'b0; end
            default: begin we = 1'b0; err = 1'b1; end
        endcase
        if (!err) begin
            m_z = (res == 0);
            m_n = ((res >> (W-1)) & 1) != 0;
        end
    endtask

    task automatic set_reg(input int addr, input int val);
        ld_en = 1'b1; ld_addr = AW'(addr); ld_data = W'(val);
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Offers one command at a negedge and observes cycles 1..8 after it.
    task automatic issue(input int op, input int rd, input int rs,
                         output int done_cyc, output int we_cnt, output int waddr,
                         output int wdata, output bit err);
        int k;
        k = 0;
        while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL issue_ready_timeout got=%0b exp=1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_opcode = opcode_t'(4'(op)); cmd_rd = AW'(rd); cmd_rs = AW'(rs);
        @(negedge clk);
        cmd_valid = 1'b0;
        done_cyc = -1; we_cnt = 0; waddr = -1; wdata = -1; err = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            if (rf_we) begin we_cnt++; waddr = int'(rf_waddr); wdata = int'(rf_wdata); end
            if (done && done_cyc < 0) begin done_cyc = c; err = cmd_err; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_z = 0; m_c = 0; m_n = 0; m_v = 0;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
        total++; if ({flag_z, flag_c, flag_n} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%03b exp=000", {flag_z, flag_c, flag_n}); end
        total++; if ({rf_we, done, cmd_err} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%03b exp=000", {rf_we, done, cmd_err}); end
    endtask

    task automatic test_add;
        int dc, wc, wa, wd, r; bit e, mw, me;
        set_reg(1, 'hF0); set_reg(2, 'h20);
        model_exec(0, 'hF0, 'h20, r, mw, me);
        issue(0, 1, 2, dc, wc, wa, wd, e);
        total++; if (dc !== 3) begin bad++; $display("FAIL add_done_cycle got=%0d exp=3", dc); end
        total++; if (wc !== 1 || wa !== 1) begin bad++; $display("FAIL add_write got=cnt%0d/addr%0d exp=cnt1/addr1", wc, wa); end
        total++; if (wd !== 'h10) begin bad++; $display("FAIL add_wdata got=%0h exp=10", wd); end
        total++; if ({flag_z, flag_c, flag_n} !== 3'b010) begin bad++; $display("FAIL add_flags got=%03b exp=010", {flag_z, flag_c, flag_n}); end
    endtask

    task automatic test_adc_sub;
        int dc, wc, wa, wd, r; bit e, mw, me;
        set_reg(3, 'h01); set_reg(4, 'h01);
        model_exec(1, 1, 1, r, mw, me);
        issue(1, 3, 4, dc, wc, wa, wd, e);
        total++; if (wd !== 'h03 || wa !== 3) begin bad++; $display("FAIL adc_wdata got=%0h@%0d exp=3@3", wd, wa); end
        total++; if ({flag_z, flag_c, flag_n} !== 3'b000) begin bad++; $display("FAIL adc_flags got=%03b exp=000", {flag_z, flag_c, flag_n}); end
        set_reg(5, 'h05); set_reg(6, 'h07);
        model_exec(2, 5, 7, r, mw, me);
        issue(2, 5, 6, dc, wc, wa, wd, e);
        total++; if (wd !== 'hFE) begin bad++; $display("FAIL sub_wdata got=%0h exp=fe", wd); end
        total++; if ({flag_z, flag_c, flag_n} !== 3'b011) begin bad++; $display("FAIL sub_flags got=%03b exp=011", {flag_z, flag_c, flag_n}); end
    endtask

    task automatic test_cmp;
        int dc, wc, wa, wd, r; bit e, mw, me;
        set_reg(5, 'h3C); set_reg(6, 'h3C);
        model_exec(10, 'h3C, 'h3C, r, mw, me);
        issue(10, 5, 6, dc, wc, wa, wd, e);
        total++; if (dc !== 3 || wc !== 0) begin bad++; $display("FAIL cmp_done_nowb got=done%0d/we%0d exp=done3/we0", dc, wc); end
        total++; if ({flag_z, flag_c, flag_n} !== 3'b100) begin bad++; $display("FAIL cmp_flags got=%03b exp=100", {flag_z, flag_c, flag_n}); end
    endtask

    task automatic test_back_to_back;
        logic [8:1] rdy, dn;
        int wds[$];
        int r1, r2; bit mw, me;
        set_reg(1, 'h5A); set_reg(2, 'h33);
        model_exec(0, 'h5A, 'h33, r1, mw, me);
        model_exec(0, r1, 'h33, r2, mw, me);
        cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_rd = AW'(1); cmd_rs = AW'(2);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            rdy[c] = cmd_ready; dn[c] = done;
            if (rf_we) wds.push_back(int'(rf_wdata));
            if (c == 5) cmd_valid = 1'b0;
        end
        total++; if (rdy !== 8'b1000_1000) begin bad++; $display("FAIL b2b_ready got=%08b exp=10001000", rdy); end
        total++; if (dn !== 8'b0100_0100) begin bad++; $display("FAIL b2b_done got=%08b exp=01000100", dn); end
        total++;
        if (wds.size() != 2 || wds[0] !== r1 || wds[1] !== r2) begin
            bad++; $display("FAIL b2b_wdata got=n%0d exp=%0h,%0h", wds.size(), r1, r2);
        end
    endtask

    task automatic test_random;
        int dc, wc, wa, wd, r, op, rd, rs, va, vb; bit e, mw, me;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 15);
            rd = $urandom_range(0, (1 << AW) - 1);
            rs = $urandom_range(0, (1 << AW) - 1);
            va = $urandom_range(0, MASK);
            vb = (op >= 8 && op <= 9) ? $urandom_range(0, W + 2) : $urandom_range(0, MASK);
            if (rd == rs) va = vb;
            set_reg(rd, va); set_reg(rs, vb);
            model_exec(op, va, vb, r, mw, me);
            issue(op, rd, rs, dc, wc, wa, wd, e);
            total++; if (dc !== 3 || e !== me) begin bad++; $display("FAIL rnd%0d_done op=%0d got=cyc%0d/err%0b exp=cyc3/err%0b", i, op, dc, e, me); end
            total++; if (wc !== int'(mw)) begin bad++; $display("FAIL rnd%0d_we op=%0d got=%0d exp=%0d", i, op, wc, mw); end
            if (mw) begin
                total++; if (wd !== r || wa !== rd) begin bad++; $display("FAIL rnd%0d_wdata op=%0d a=%0h b=%0h got=%0h@%0d exp=%0h@%0d", i, op, va, vb, wd, wa, r, rd); end
            end
            total++; if ({flag_z, flag_c, flag_n} !== {m_z, m_c, m_n}) begin bad++; $display("FAIL rnd%0d_flags op=%0d a=%0h b=%0h got=%03b exp=%03b", i, op, va, vb, {flag_z, flag_c, flag_n}, {m_z, m_c, m_n}); end
`ifdef ALU_OVF_EN
            total++; if (flag_v !== m_v) begin bad++; $display("FAIL rnd%0d_v op=%0d got=%0b exp=%0b", i, op, flag_v, m_v); end
`endif
        end
    endtask

    task automatic test_reset_mid;
        int wc;
        set_reg(1, 'hF0); set_reg(2, 'h20);
        cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_rd = AW'(1); cmd_rs = AW'(2);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        m_z = 0; m_c = 0; m_n = 0; m_v = 0;
        wc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (rf_we || done) wc++;
        end
        total++; if (wc !== 0) begin bad++; $display("FAIL rstmid_no_we got=%0d exp=0", wc); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b exp=1", cmd_ready); end
        total++; if ({flag_z, flag_c, flag_n} !== 3'b000) begin bad++; $display("FAIL rstmid_flags got=%03b exp=000", {flag_z, flag_c, flag_n}); end
    endtask

`ifdef ALU_OVF_EN
    task automatic test_ovf;
        int dc, wc, wa, wd, r; bit e, mw, me;
        logic [3:0] before;
        set_reg(1, 'h7F); set_reg(2, 'h01);
        model_exec(0, 'h7F, 'h01, r, mw, me);
        issue(0, 1, 2, dc, wc, wa, wd, e);
        total++; if (wd !== 'h80 || flag_v !== 1'b1 || flag_n !== 1'b1) begin bad++; $display("FAIL ovf_add got=%0h/v%0b/n%0b exp=80/v1/n1", wd, flag_v, flag_n); end
        before = {flag_z, flag_c, flag_n, flag_v};
        issue(15, 1, 2, dc, wc, wa, wd, e);
        total++; if (e !== 1'b1 || wc !== 0) begin bad++; $display("FAIL ovf_unsup got=err%0b/we%0d exp=err1/we0", e, wc); end
        total++; if ({flag_z, flag_c, flag_n, flag_v} !== before) begin bad++; $display("FAIL ovf_unsup_flags got=%04b exp=%04b", {flag_z, flag_c, flag_n, flag_v}, before); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) rf[i] = '0;
        test_reset;
        test_add;
        test_adc_sub;
        test_cmp;
        test_back_to_back;
        test_random;
        test_reset_mid;
`ifdef ALU_OVF_EN
        test_ovf;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
Multi-cycle sequencer that executes one register-to-register ALU instruction per command. Reads operands from the external register file, drives an internal `alu` instance, computes flags, and writes the result back. Sits between the decode/control unit and the register file. Holds the architectural Z/C/N flags and applies carry-in for ADC.

Parameters:
WORD_SIZE, `WORD_SIZE (8), datapath width in bits.
REG_ADDR_W, 3, register-file address width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_opcode  in  opcode_t  ALU operation
cmd_rd  in  REG_ADDR_W  destination / operand A register
cmd_rs  in  REG_ADDR_W  operand B register
rf_raddr_a  out  REG_ADDR_W  read port A address
rf_raddr_b  out  REG_ADDR_W  read port B address
rf_rdata_a  in  WORD_SIZE  read data A, one-cycle latency
rf_rdata_b  in  WORD_SIZE  read data B, one-cycle latency
rf_we  out  1  write-enable pulse
rf_waddr  out  REG_ADDR_W  write address
rf_wdata  out  WORD_SIZE  write data
done  out  1  one-cycle pulse: instruction retired
cmd_err  out  1  valid with done: unsupported opcode
flag_z, flag_c, flag_n  out  1 each  architectural flags

Behaviour:
- Reset:
  - Async, active-low. State returns to IDLE.
  - All outputs and flags go to 0, except cmd_ready = 1.
  - Latched command discarded; no rf_we is ever issued after reset mid-operation.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On valid&ready, latch opcode/rd/rs, go to READ.
  - READ: rf_raddr_a=rd, rf_raddr_b=rs. Go to EXEC.
  - EXEC: latch operands into the ALU, register result and flags. Go to WB.
  - WB: done=1. rf_we=1 unless opcode is CMP or unsupported. Go to IDLE.
- Latency and throughput:
  - Accept at cycle 0 → done at cycle 3.
  - Next accept no earlier than cycle 4; throughput 1 instruction / 4 cycles.
- cmd_ready is 0 outside IDLE. cmd_valid is ignored there; no queuing.
- Arithmetic rules (sums computed at WORD_SIZE+1 bits on latched operands):
  - ADD: C = carry out.
  - ADC: result = a+b+flag_c; C = carry out.
  - SUB: C = borrow (a<b unsigned).
  - INC/DEC: b ignored. C = wrap (a=all-ones for INC, a=0 for DEC).
  - AND/OR/XOR/SHL/SHR: C=0.
  - Shift amount ≥ WORD_SIZE yields 0.
  - CMP: no writeback. Z=(a==b), C=(a<b unsigned), N=msb(a−b).
  - All others: Z=(result==0), N=result msb.
- Unsupported opcode: flags unchanged, no rf_we, done=1 with cmd_err=1.
- Flags update only in EXEC; stable otherwise.
- rf_waddr/rf_wdata registered, held valid during WB.

Optional Feature:
ALU_OVF_EN
- Defined: adds output flag_v (signed overflow), reset 0.
  - Updated for ADD/ADC/SUB/INC/DEC/CMP.
  - Cleared for logic ops and shifts.
- Undefined: flag_v port and logic absent; other behaviour identical.

Decomposition:
- opcode_t and WORD_SIZE come from the shared config package.
- Add to the package: the FSM state enum ctrl_state_t and a function is_writeback(opcode_t).
- One sub-module: `alu`, instantiated inside `alu_ctrl`.
  - ADC carry-in is added in the controller, not in `alu`.

Test Plan:
- Reset release → cmd_ready=1, flags 0, rf_we=0.
  - Assert rst_n=0 during EXEC of ADD → no rf_we, flags 0, cmd_ready=1.
- ADD R1=0xF0, R2=0x20 → rf_we at cycle 3, rf_waddr=1, rf_wdata=0x10, C=1, Z=0, N=0, done=1.
- ADC with flag_c=1, R3=0x01, R4=0x01 → rf_wdata=0x03, C=0.
  - Then SUB 0x05−0x07 → rf_wdata=0xFE, C=1, N=1.
- CMP R5=0x3C, R6=0x3C → done, no rf_we, Z=1, C=0, N=0.
- cmd_valid held high with two ADDs → accepted at cycles 0 and 4.
  - cmd_ready low in cycles 1–3; second done at cycle 7.
- ALU_OVF_EN build: ADD 0x7F+0x01 → rf_wdata=0x80, flag_v=1, N=1.
  - Unsupported opcode → cmd_err=1, flags unchanged.
